// File: rtl/student_stream_mixer.sv
// N-channel audio stream mixer: per-channel requantisation, gain, summation
// and output saturation, one channel per cycle, triggered by an IIS frame tick.
// Optional build macro STUDENT_MIXER_ROUND_EN selects round-half-up
// requantisation instead of a plain truncating shift.
module student_stream_mixer #(
    parameter int NUM_CH     = 2,
    parameter int DATA_IN_W  = 64,
    parameter int DATA_OUT_W = 16,
    parameter int SHIFT      = 15,
    parameter int GAIN_W     = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_CH-1:0]              ch_valid_i,
    input  logic [NUM_CH*DATA_IN_W-1:0]    ch_data_i,
    input  logic [NUM_CH-1:0]              ch_enable_i,
    input  logic [NUM_CH*GAIN_W-1:0]       gain_i,
    input  logic                           frame_strobe_i,
    input  logic                           clear_i,
    output logic [DATA_OUT_W-1:0]          mix_o,
    output logic                           mix_valid_o,
    output logic                           sat_o,
    output logic                           overrun_o
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = DATA_OUT_W + GAIN_W + 1;
    localparam int ACC_W  = DATA_OUT_W + GAIN_W + $clog2(NUM_CH) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    // Clamp bounds for the requantised sample and for the final sum.
    localparam logic signed [DATA_IN_W:0] S_MAX =
        {{(DATA_IN_W - DATA_OUT_W + 2){1'b0}}, {(DATA_OUT_W - 1){1'b1}}};
    localparam logic signed [DATA_IN_W:0] S_MIN = ~S_MAX;
    localparam logic signed [ACC_W-1:0]   A_MAX =
        {{(ACC_W - DATA_OUT_W + 1){1'b0}}, {(DATA_OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0]   A_MIN = ~A_MAX;

    logic [1:0]                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q;
    logic signed [ACC_W-1:0]       acc_q;
    logic [DATA_IN_W-1:0]          hold_q [NUM_CH];
    logic [NUM_CH-1:0]             pending_q, pending_d;
    logic [DATA_OUT_W-1:0]         mix_q;
    logic                          mix_valid_q;
    logic                          sat_q, overrun_q;

    logic [GAIN_W-1:0]             gain_arr [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_gain
            assign gain_arr[gi] = gain_i[gi*GAIN_W +: GAIN_W];
        end
    endgenerate

    // Datapath for the channel currently selected by idx_q.
    logic [DATA_IN_W-1:0]          sel_hold;
    logic [GAIN_W-1:0]             sel_gain;
    logic                          sel_en;
    logic signed [DATA_IN_W:0]     ext;
    logic signed [DATA_IN_W:0]     shifted;
    logic                          ch_clamp;
    logic signed [DATA_OUT_W-1:0]  s_val;
    logic signed [GAIN_W:0]        gain_s;
    logic signed [PROD_W-1:0]      prod;
    logic signed [PROD_W-1:0]      term;
    logic signed [ACC_W-1:0]       term_eff;
    logic signed [ACC_W-1:0]       acc_sum;
    logic                          out_clamp;
    logic [DATA_OUT_W-1:0]         mix_sat;

`ifdef STUDENT_MIXER_ROUND_EN
    localparam logic signed [DATA_IN_W:0] HALF = (DATA_IN_W + 1)'(1) << (SHIFT - 1);
`endif

    // Requantise, clamp, scale and accumulate the selected channel.
    always_comb begin
        sel_hold = hold_q[idx_q];
        sel_gain = gain_arr[idx_q];
        sel_en   = ch_enable_i[idx_q];
        ext      = {sel_hold[DATA_IN_W-1], sel_hold};
`ifdef STUDENT_MIXER_ROUND_EN
        shifted  = (ext + HALF) >>> SHIFT;
`else
        shifted  = ext >>> SHIFT;
`endif
        ch_clamp = 1'b0;
        if (shifted > S_MAX) begin
            s_val    = S_MAX[DATA_OUT_W-1:0];
            ch_clamp = 1'b1;
        end else if (shifted < S_MIN) begin
            s_val    = S_MIN[DATA_OUT_W-1:0];
            ch_clamp = 1'b1;
        end else begin
            s_val    = shifted[DATA_OUT_W-1:0];
        end
        gain_s   = {1'b0, sel_gain};
        prod     = PROD_W'(s_val) * PROD_W'(gain_s);
        term     = prod >>> (GAIN_W - 1);
        term_eff = sel_en ? ACC_W'(term) : '0;
        acc_sum  = acc_q + term_eff;
        out_clamp = 1'b0;
        if (acc_sum > A_MAX) begin
            mix_sat   = A_MAX[DATA_OUT_W-1:0];
            out_clamp = 1'b1;
        end else if (acc_sum < A_MIN) begin
            mix_sat   = A_MIN[DATA_OUT_W-1:0];
            out_clamp = 1'b1;
        end else begin
            mix_sat   = acc_sum[DATA_OUT_W-1:0];
        end
    end

    // Next state of the mix-pass sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame_strobe_i) state_d = ST_ACCUM;
            ST_ACCUM:  if (idx_q == IDX_W'(NUM_CH - 1)) state_d = ST_OUTPUT;
            ST_OUTPUT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pending bits: cleared by the pass as each channel is consumed, but a
    // fresh capture in the same cycle keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (state_q == ST_ACCUM) pending_d[idx_q] = 1'b0;
        pending_d = pending_d | ch_valid_i;
    end

    // Capture, sequencing, accumulation and sticky flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            pending_q   <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mix_valid_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid_i[k]) hold_q[k] <= ch_data_i[k*DATA_IN_W +: DATA_IN_W];
            end

            if (state_q == ST_IDLE && frame_strobe_i) begin
                acc_q <= '0;
                idx_q <= '0;
            end else if (state_q == ST_ACCUM) begin
                acc_q <= acc_sum;
                idx_q <= idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_CH - 1)) begin
                    mix_q       <= mix_sat;
                    mix_valid_q <= 1'b1;
                end
            end

            // Clear first, then any new event re-sets the flag.
            if (clear_i) begin
                sat_q     <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (state_q == ST_ACCUM && sel_en &&
                (ch_clamp || (idx_q == IDX_W'(NUM_CH - 1) && out_clamp)))
                sat_q <= 1'b1;
            if ((|(ch_valid_i & pending_q)) ||
                (frame_strobe_i && state_q != ST_IDLE))
                overrun_q <= 1'b1;
            if (state_q == ST_ACCUM && idx_q == IDX_W'(NUM_CH - 1) && out_clamp)
                sat_q <= 1'b1;
        end
    end

    assign mix_o       = mix_q;
    assign mix_valid_o = mix_valid_q;
    assign sat_o       = sat_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_student_stream_mixer.sv
// Directed testbench for student_stream_mixer (default parameters).
module tb_student_stream_mixer;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    ch_valid_i;
    logic [127:0]  ch_data_i;
    logic [1:0]    ch_enable_i;
    logic [15:0]   gain_i;
    logic          frame_strobe_i;
    logic          clear_i;
    logic [15:0]   mix_o;
    logic          mix_valid_o;
    logic          sat_o;
    logic          overrun_o;

    int checks   = 0;
    int failures = 0;

    student_stream_mixer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ch_valid_i     (ch_valid_i),
        .ch_data_i      (ch_data_i),
        .ch_enable_i    (ch_enable_i),
        .gain_i         (gain_i),
        .frame_strobe_i (frame_strobe_i),
        .clear_i        (clear_i),
        .mix_o          (mix_o),
        .mix_valid_o    (mix_valid_o),
        .sat_o          (sat_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
        end else begin
            $display("ok   %s value=%0d", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int k, input longint v);
        ch_data_i[k*64 +: 64] = v;
        ch_valid_i[k] = 1'b1;
        tick();
        ch_valid_i = '0;
    endtask

    // Issue one frame strobe, wait for the pulse, check latency and sample.
    task automatic run_frame(input string tag, input int exp_mix);
        int n;
        frame_strobe_i = 1'b1;
        tick();
        frame_strobe_i = 1'b0;
        n = 1;
        while (!mix_valid_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_mix"}, int'($signed(mix_o)), exp_mix);
        tick();
        check({tag, "_valid_drop"}, int'(mix_valid_o), 0);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        int pulses;
        rst_i = 1'b1; ch_valid_i = '0; ch_data_i = '0; ch_enable_i = '0;
        gain_i = '0; frame_strobe_i = 1'b0; clear_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_mix", int'(mix_o), 0);
        check("rst_valid", int'(mix_valid_o), 0);
        check("rst_sat", int'(sat_o), 0);
        check("rst_overrun", int'(overrun_o), 0);

        // Basic pass: ch1 disabled.
        gain_i = {8'd128, 8'd128};
        ch_enable_i = 2'b01;
        load(0, 64'sd32768000);
        load(1, 64'sd99 <<< 15);
        run_frame("basic", 1000);
        check("basic_sat", int'(sat_o), 0);

        // Output saturation both directions.
        ch_enable_i = 2'b11;
        load(0, 64'sd30000 <<< 15);
        load(1, 64'sd30000 <<< 15);
        run_frame("sat_pos", 32767);
        check("sat_pos_flag", int'(sat_o), 1);
        load(0, -(64'sd30000 <<< 15));
        load(1, -(64'sd30000 <<< 15));
        run_frame("sat_neg", -32768);
        pulse_clear();
        check("sat_cleared", int'(sat_o), 0);

        // Gain scaling: 500 + (-399).
        gain_i = {8'd255, 8'd64};
        load(0, 64'sd1000 <<< 15);
        load(1, -(64'sd200 <<< 15));
        run_frame("gain", 101);
        check("gain_sat", int'(sat_o), 0);
        check("gain_overrun", int'(overrun_o), 0);

        // Per-channel clamp: 32767*64>>>7 = 16383, no output clamp.
        ch_enable_i = 2'b01;
        load(0, 64'sd40000 <<< 15);
        run_frame("chclamp", 16383);
        check("chclamp_sat", int'(sat_o), 1);
        pulse_clear();

        // Overrun and sample-and-hold.
        gain_i = {8'd128, 8'd128};
        load(0, 64'sd5 <<< 15);
        load(0, 64'sd7 <<< 15);
        check("ovr_flag", int'(overrun_o), 1);
        run_frame("ovr", 7);
        run_frame("hold", 7);
        pulse_clear();
        check("ovr_cleared", int'(overrun_o), 0);

        // Strobe held into ACCUM: ignored, sets overrun, one pulse only.
        frame_strobe_i = 1'b1;
        tick();
        tick();
        frame_strobe_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (mix_valid_o) pulses++;
            tick();
        end
        check("busy_pulses", pulses, 1);
        check("busy_overrun", int'(overrun_o), 1);
        check("busy_mix", int'($signed(mix_o)), 7);

        // Reset during ACCUM: no pulse, everything zero.
        frame_strobe_i = 1'b1;
        tick();
        frame_strobe_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (mix_valid_o) pulses++;
            tick();
        end
        check("rst_abort_pulses", pulses, 0);
        check("rst_abort_mix", int'(mix_o), 0);
        check("rst_abort_overrun", int'(overrun_o), 0);
        check("rst_abort_sat", int'(sat_o), 0);
        run_frame("rst_hold_zero", 0);

        // Requantisation rounding boundary.
        load(0, 64'sd3 <<< 14);
`ifdef STUDENT_MIXER_ROUND_EN
        run_frame("round_pos", 2);
`else
        run_frame("round_pos", 1);
`endif
        load(0, -(64'sd3 <<< 14));
`ifdef STUDENT_MIXER_ROUND_EN
        run_frame("round_neg", -1);
`else
        run_frame("round_neg", -2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/student_stream_mixer.md
Name: student_stream_mixer

Overview:
- Parametrised N-channel audio stream mixer.
- Sits between the FIR engine outputs and the IIS handler. It replaces the hard-wired single 64-bit FIR result path with per-channel requantisation, gain, summation and saturation.
- Each channel result is captured on its valid strobe. A frame strobe from the IIS side starts one sequential mix pass, and the pass ends with a single registered 16-bit sample plus a valid pulse.

Parameters:
- NUM_CH, 2, number of input channels (≥1).
- DATA_IN_W, 64, signed width of each channel input.
- DATA_OUT_W, 16, signed width of mixed output.
- SHIFT, 15, arithmetic right shift applied to each channel input (requantisation).
- GAIN_W, 8, unsigned per-channel gain width; 2^(GAIN_W-1) = unity.

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, synchronous active-high reset.
- ch_valid_i, input, NUM_CH, per-channel one-cycle valid strobe.
- ch_data_i, input, NUM_CH*DATA_IN_W, packed signed channel data; channel k at [k*DATA_IN_W +: DATA_IN_W].
- ch_enable_i, input, NUM_CH, channel k contributes only when set.
- gain_i, input, NUM_CH*GAIN_W, packed unsigned gains.
- frame_strobe_i, input, 1, start of a mix pass (IIS sample tick).
- clear_i, input, 1, clears sticky flags.
- mix_o, output, DATA_OUT_W, mixed signed sample.
- mix_valid_o, output, 1, one-cycle pulse when mix_o is updated.
- sat_o, output, 1, sticky saturation flag.
- overrun_o, output, 1, sticky overrun flag.

Behaviour:
- Reset: mix_o=0, mix_valid_o=0, sat_o=0, overrun_o=0, all hold registers=0, pending=0, state=IDLE. rst_i mid-pass aborts the pass; no mix_valid_o pulse follows.
- Capture:
  - ch_valid_i[k] loads hold[k] and sets pending[k] in every state.
  - If pending[k] is already set, overrun_o is set and the newest value wins.
- Hold semantics: hold[k] is sample-and-hold. An enabled channel with no new data re-uses its last value. pending[k] is used only for overrun detection.
- FSM IDLE -> ACCUM -> OUTPUT -> IDLE.
  - IDLE: frame_strobe_i=1 -> acc=0, idx=0, go to ACCUM.
  - ACCUM: processes channel idx in one cycle; pending[idx] is cleared. idx=NUM_CH-1 -> OUTPUT, else idx+1.
  - OUTPUT: mix_o = sat(acc); mix_valid_o=1 for one cycle; -> IDLE.
- Latency: frame_strobe_i at cycle t -> mix_valid_o and new mix_o at cycle t+NUM_CH+1. mix_o holds its value until the next OUTPUT.
- frame_strobe_i in ACCUM or OUTPUT is ignored and sets overrun_o.
- Per-channel arithmetic:
  - s = hold[k] >>> SHIFT (truncation toward -inf), saturated to signed DATA_OUT_W.
  - p = s * {0,gain} (signed, DATA_OUT_W+GAIN_W+1 bits); term = p >>> (GAIN_W-1).
  - Disabled channel: term = 0, and pending is still cleared.
- Accumulator: signed, DATA_OUT_W+GAIN_W+$clog2(NUM_CH)+1 bits; it never wraps.
- Output saturation clamps to [-2^(DATA_OUT_W-1), 2^(DATA_OUT_W-1)-1].
- sat_o is set on any per-channel clamp or any output clamp.
- Simultaneous events:
  - ch_valid_i[k] in the same cycle ACCUM processes k: the term uses the old hold[k], and pending[k] stays set (capture wins).
  - clear_i together with a new flag event: the set wins.

Optional Feature:
- Macro: STUDENT_MIXER_ROUND_EN.
- Defined: requantisation rounds half-up, s = (hold[k] + 2^(SHIFT-1)) >>> SHIFT, before saturation. Gain scaling remains truncating.
- Undefined: plain truncating shift as specified above.

Test Plan:
- Basic pass (NUM_CH=2, SHIFT=15, GAIN_W=8):
  - Stimulus: ch0 = 32768000, gain0=128, ch1 disabled, frame_strobe_i at t.
  - Response: mix_o=1000 with mix_valid_o at t+3; sat_o=0.
- Saturation:
  - Stimulus: ch0 = ch1 = 30000<<15, gains 128. Then both -30000<<15.
  - Response: mix_o=32767, sat_o=1. Then mix_o=-32768. clear_i -> sat_o=0.
- Gain:
  - Stimulus: ch0=1000<<15 with gain 64; ch1=-200<<15 with gain 255.
  - Response: terms 500 and -399; mix_o=101.
- Overrun and hold:
  - Stimulus: ch_valid_i[0] twice (values 5<<15 then 7<<15) before a frame.
  - Response: overrun_o=1, mix_o=7.
  - Next frame with no new data: mix_o=7 again.
- Busy and reset:
  - Stimulus: frame_strobe_i during ACCUM.
  - Response: the strobe is ignored, overrun_o=1, exactly one mix_valid_o pulse.
  - Stimulus: rst_i asserted in ACCUM.
  - Response: no pulse; all outputs 0.
- Rounding:
  - Stimulus: ch0 = 3<<14, gain 128.
  - Response: mix_o=1 without STUDENT_MIXER_ROUND_EN; mix_o=2 with it.
